// File: rtl/game_pkg.sv
// Shared types and screen constants for the game sequencer and its
// collision datapath.
package game_pkg;

  localparam int COORD_W  = 10;
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int X_CENTRE = H_RES / 2;
  localparam int Y_CENTRE = V_RES / 2;

  typedef enum logic [1:0] {
    MENU,
    RUN,
    PAUSE,
    OVER
  } state_t;

  // Scan order: four enemies, then the food object last.
  typedef enum logic [2:0] {
    OBJ_E1,
    OBJ_E2,
    OBJ_E3,
    OBJ_E4,
    OBJ_F1
  } obj_idx_t;

endpackage

// File: rtl/collision_dist.sv
// Registered circle-overlap test: hit is high one cycle after the inputs
// when the squared centre distance is within rsum squared.
module collision_dist
  import game_pkg::*;
(
  input  logic               clk_d,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] ox,
  input  logic [COORD_W-1:0] oy,
  input  logic [5:0]         rsum,
  output logic               hit
);

  logic signed [10:0] dx, dy;
  logic signed [21:0] dx_w, dy_w;
  logic [20:0]        d2;
  logic [9:0]         rsum_w, rsq;

  assign dx     = $signed({1'b0, ox}) - $signed({1'b0, px});
  assign dy     = $signed({1'b0, oy}) - $signed({1'b0, py});
  assign dx_w   = 22'(dx);
  assign dy_w   = 22'(dy);
  assign d2     = 21'(dx_w * dx_w + dy_w * dy_w);
  assign rsum_w = {4'd0, rsum};
  assign rsq    = rsum_w * rsum_w;

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) hit <= 1'b0;
    else        hit <= (d2 <= {11'd0, rsq});
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: menu/run/pause/over FSM, per-frame player move with
// border clamp, five-object collision scan and radius shrink/grow.
module game_ctrl
  import game_pkg::*;
#(
  parameter int STEP         = 2,
  parameter int R_MAX        = 20,
  parameter int R_MIN        = 10,
  parameter int R_STEP       = 2,
  parameter int OBJ_R        = 10,
  parameter int BORDER       = 15,
  parameter int GRACE_FRAMES = 60
) (
  input  logic               clk_d,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic [COORD_W-1:0] E1x,
  input  logic [COORD_W-1:0] E1y,
  input  logic [COORD_W-1:0] E2x,
  input  logic [COORD_W-1:0] E2y,
  input  logic [COORD_W-1:0] E3x,
  input  logic [COORD_W-1:0] E3y,
  input  logic [COORD_W-1:0] E4x,
  input  logic [COORD_W-1:0] E4y,
  input  logic [COORD_W-1:0] F1x,
  input  logic [COORD_W-1:0] F1y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [5:0]         r,
  output logic               gamemenu,
  output logic               gamerun,
  output logic               gamepause,
  output logic               food_eaten
);

  localparam int GRACE_W = $clog2(GRACE_FRAMES + 1);

  state_t               state_q, state_n;
  logic                 start_q, pause_q, start_rise, pause_rise;
  logic                 leave_run, frame_go, apply_p1;
  logic                 scan_busy, vld_p1, enemy_acc, hit_p1;
  obj_idx_t             scan_idx, idx_p1;
  logic [GRACE_W-1:0]   grace;
  logic [COORD_W-1:0]   obj_x, obj_y;
  logic [5:0]           rsum, r_hit;
  logic signed [11:0]   r_s, step_x, step_y, x_lo, x_hi, y_lo, y_hi, nx, ny;

  function automatic logic [COORD_W-1:0] clamp_pos(input logic signed [11:0] p,
                                                   input logic signed [11:0] lo,
                                                   input logic signed [11:0] hi);
    if (p < lo) return COORD_W'(lo);
    if (p > hi) return COORD_W'(hi);
    return COORD_W'(p);
  endfunction

  function automatic logic [5:0] r_shrink(input logic [5:0] rv);
    if (rv >= 6'(R_MIN + R_STEP)) return rv - 6'(R_STEP);
    return 6'(R_MIN);
  endfunction

  function automatic logic [5:0] r_grow(input logic [5:0] rv);
    if ({1'b0, rv} + 7'(R_STEP) >= 7'(R_MAX)) return 6'(R_MAX);
    return rv + 6'(R_STEP);
  endfunction

  assign start_rise = btn_start & ~start_q;
  assign pause_rise = btn_pause & ~pause_q;

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      pause_q <= 1'b0;
      state_q <= MENU;
    end else begin
      start_q <= btn_start;
      pause_q <= btn_pause;
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      MENU:    if (start_rise) state_n = RUN;
      RUN: begin
        if (r == 6'(R_MIN))  state_n = OVER;
        else if (pause_rise) state_n = PAUSE;
      end
      PAUSE: begin
        if (start_rise)      state_n = MENU;
        else if (pause_rise) state_n = RUN;
      end
      OVER:    if (start_rise) state_n = MENU;
      default: state_n = MENU;
    endcase
  end

  assign gamemenu  = (state_q == MENU);
  assign gamerun   = (state_q == RUN);
  assign gamepause = (state_q == PAUSE);

  // Any exit from RUN cancels an in-flight scan, so no stale hit is applied.
  assign leave_run = (state_n != RUN);
  assign frame_go  = frame_tick && (state_q == RUN) && !leave_run && !scan_busy && !vld_p1;
  assign apply_p1  = vld_p1 && (idx_p1 == OBJ_F1) && !leave_run;

  assign r_s    = $signed({6'd0, r});
  assign step_x = (btn_right ? 12'(STEP) : 12'sd0) - (btn_left ? 12'(STEP) : 12'sd0);
  assign step_y = (btn_down  ? 12'(STEP) : 12'sd0) - (btn_up   ? 12'(STEP) : 12'sd0);
  assign x_lo   = 12'(BORDER) + r_s;
  assign x_hi   = 12'(H_RES - BORDER) - r_s;
  assign y_lo   = 12'(BORDER) + r_s;
  assign y_hi   = 12'(V_RES - BORDER) - r_s;
  assign nx     = $signed({2'b00, x}) + step_x;
  assign ny     = $signed({2'b00, y}) + step_y;

  always_comb begin
    r_hit = r;
    if (enemy_acc && grace == '0) r_hit = r_shrink(r_hit);
    if (hit_p1)                   r_hit = r_grow(r_hit);
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      x          <= COORD_W'(X_CENTRE);
      y          <= COORD_W'(Y_CENTRE);
      r          <= 6'(R_MAX);
      grace      <= '0;
      food_eaten <= 1'b0;
    end else begin
      food_eaten <= 1'b0;
      if (state_q == MENU && state_n == RUN) begin
        x     <= COORD_W'(X_CENTRE);
        y     <= COORD_W'(Y_CENTRE);
        r     <= 6'(R_MAX);
        grace <= '0;
      end else begin
        if (frame_go) begin
          x <= clamp_pos(nx, x_lo, x_hi);
          y <= clamp_pos(ny, y_lo, y_hi);
          if (grace != '0) grace <= grace - 1'b1;
        end
        if (apply_p1) begin
          r          <= r_hit;
          food_eaten <= hit_p1;
          if (enemy_acc && grace == '0) grace <= GRACE_W'(GRACE_FRAMES);
        end
      end
    end
  end

  always_comb begin
    obj_x = E1x;
    obj_y = E1y;
    case (scan_idx)
      OBJ_E2:  begin obj_x = E2x; obj_y = E2y; end
      OBJ_E3:  begin obj_x = E3x; obj_y = E3y; end
      OBJ_E4:  begin obj_x = E4x; obj_y = E4y; end
      OBJ_F1:  begin obj_x = F1x; obj_y = F1y; end
      default: ;
    endcase
  end

  assign rsum = r + 6'(OBJ_R);

  // Stage p0 -> p1: object selected by scan_idx, hit returns with idx_p1.
  collision_dist u_dist (
    .clk_d (clk_d),
    .rst_n (rst_n),
    .px    (x),
    .py    (y),
    .ox    (obj_x),
    .oy    (obj_y),
    .rsum  (rsum),
    .hit   (hit_p1)
  );

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      scan_busy <= 1'b0;
      scan_idx  <= OBJ_E1;
      vld_p1    <= 1'b0;
      idx_p1    <= OBJ_E1;
      enemy_acc <= 1'b0;
    end else if (leave_run) begin
      scan_busy <= 1'b0;
      scan_idx  <= OBJ_E1;
      vld_p1    <= 1'b0;
      enemy_acc <= 1'b0;
    end else begin
      vld_p1 <= scan_busy;
      idx_p1 <= scan_idx;
      if (frame_go) begin
        scan_busy <= 1'b1;
        scan_idx  <= OBJ_E1;
      end else if (scan_busy) begin
        if (scan_idx == OBJ_F1) scan_busy <= 1'b0;
        else                    scan_idx  <= obj_idx_t'(scan_idx + 3'd1);
      end
      if (vld_p1 && idx_p1 == OBJ_F1)  enemy_acc <= 1'b0;
      else if (vld_p1 && hit_p1)       enemy_acc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: movement table plus hand-written hit,
// food, pause-abort and game-over sequences.
module tb_game_ctrl;

  logic       clk_d = 1'b0;
  logic       rst_n, frame_tick, btn_start, btn_pause;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [9:0] E1x, E1y, E2x, E2y, E3x, E3y, E4x, E4y, F1x, F1y;
  logic [9:0] x, y;
  logic [5:0] r;
  logic       gamemenu, gamerun, gamepause, food_eaten;

  int checks   = 0;
  int failures = 0;

  logic [5:0] r_at   [10];
  logic       fe_at  [10];
  logic       menu_at[10];
  logic       run_at [10];
  logic       pse_at [10];

  typedef struct {
    logic up, down, left, right;
    int   frames;
    int   exp_x, exp_y;
  } mv_vec_t;

  mv_vec_t vecs[8];

  game_ctrl dut (
    .clk_d(clk_d), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .E1x(E1x), .E1y(E1y), .E2x(E2x), .E2y(E2y), .E3x(E3x), .E3y(E3y),
    .E4x(E4x), .E4y(E4y), .F1x(F1x), .F1y(F1y),
    .x(x), .y(y), .r(r),
    .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause),
    .food_eaten(food_eaten)
  );

  always #5 clk_d = ~clk_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_d);
      #1;
    end
  endtask

  // One frame: tick in cycle T, outputs captured mid-cycle for T..T+9.
  task automatic frame(input int pause_k);
    frame_tick = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == pause_k) btn_pause = 1'b1;
      @(negedge clk_d);
      r_at[k]    = r;
      fe_at[k]   = food_eaten;
      menu_at[k] = gamemenu;
      run_at[k]  = gamerun;
      pse_at[k]  = gamepause;
      @(posedge clk_d);
      #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    cyc(1);
    btn_start = 1'b0;
    cyc(1);
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    cyc(1);
    btn_pause = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic fe_any;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1,  10, 340, 240};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0,   5, 340, 230};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0,   3, 334, 230};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1,   4, 334, 238};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 140, 605, 238};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 130, 605, 445};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 300,  35, 445};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 250,  35,  35};

    rst_n = 1'b0; frame_tick = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    E1x = 10'd0; E1y = 10'd0; E2x = 10'd0; E2y = 10'd0; E3x = 10'd0; E3y = 10'd0;
    E4x = 10'd0; E4y = 10'd0; F1x = 10'd0; F1y = 10'd0;
    cyc(3);
    chk("rst_x", x, 320);
    chk("rst_y", y, 240);
    chk("rst_r", r, 20);
    chk("rst_menu", gamemenu, 1);
    chk("rst_run", gamerun, 0);
    chk("rst_pause", gamepause, 0);
    chk("rst_food", food_eaten, 0);
    rst_n = 1'b1;
    cyc(2);

    btn_start = 1'b1;
    cyc(1);
    chk("start_run", gamerun, 1);
    chk("start_menu", gamemenu, 0);
    chk("start_x", x, 320);
    chk("start_y", y, 240);
    chk("start_r", r, 20);
    btn_start = 1'b0;
    cyc(1);

    for (int i = 0; i < 8; i++) begin
      btn_up = vecs[i].up; btn_down = vecs[i].down;
      btn_left = vecs[i].left; btn_right = vecs[i].right;
      repeat (vecs[i].frames) frame(-1);
      chk($sformatf("move%0d_x", i), x, vecs[i].exp_x);
      chk($sformatf("move%0d_y", i), y, vecs[i].exp_y);
      chk($sformatf("move%0d_r", i), r, 20);
    end
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;

    // RUN -> PAUSE -> MENU -> RUN reloads the player.
    press_pause();
    chk("pause_flag", gamepause, 1);
    press_start();
    chk("pause_to_menu", gamemenu, 1);
    press_start();
    chk("restart_run", gamerun, 1);
    chk("restart_x", x, 320);
    chk("restart_r", r, 20);

    E1x = 10'd345; E1y = 10'd240;
    frame(-1);
    chk("hit_r_T6", r_at[6], 20);
    chk("hit_r_T7", r_at[7], 18);
    chk("hit_no_food", fe_at[7], 0);
    frame(-1);
    chk("grace_r", r_at[9], 18);
    E1x = 10'd0; E1y = 10'd0;

    F1x = 10'd320; F1y = 10'd250;
    frame(-1);
    chk("food_r_T6", r_at[6], 18);
    chk("food_r_T7", r_at[7], 20);
    chk("food_pulse_T6", fe_at[6], 0);
    chk("food_pulse_T7", fe_at[7], 1);
    chk("food_pulse_T8", fe_at[8], 0);
    frame(-1);
    chk("food_sat_r", r_at[9], 20);
    chk("food_sat_pulse", fe_at[7], 1);

    // Pause rising in T+4 must abort the scan with the food still overlapping.
    frame(4);
    btn_pause = 1'b0;
    fe_any = 1'b0;
    for (int k = 0; k < 10; k++) fe_any = fe_any | fe_at[k];
    chk("abort_pause_T5", pse_at[5], 1);
    chk("abort_no_food", fe_any, 0);
    chk("abort_r", r_at[9], 20);
    cyc(1);
    press_pause();
    chk("resume_run", gamerun, 1);
    F1x = 10'd0; F1y = 10'd0;

    repeat (65) frame(-1);
    for (int h = 0; h < 5; h++) begin
      E1x = 10'd325; E1y = 10'd240;
      frame(-1);
      chk($sformatf("over_hit%0d_r", h), r_at[7], 18 - 2 * h);
      E1x = 10'd0; E1y = 10'd0;
      if (h < 4) repeat (62) frame(-1);
    end
    chk("over_run_T7", run_at[7], 1);
    chk("over_run_T8", run_at[8], 0);
    chk("over_menu_T8", menu_at[8], 0);
    chk("over_pause_T8", pse_at[8], 0);
    frame(-1);
    chk("over_hold_r", r_at[9], 10);
    press_start();
    chk("over_to_menu", gamemenu, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
